// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage divider: FSM encodings, handshake levels
// and result bus width.
package ex_div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam int unsigned DivResW           = 64;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for the EX stage: DIV/DIVU, 32 steps,
// result {remainder, quotient} with a start/ready handshake.
module ex_div
    import ex_div_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [31:0]        opdata1_i,
    input  logic [31:0]        opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [DivResW-1:0] result_o,
    output logic               ready_o
);

    div_state_e         r_state;
    div_state_e         w_state_nxt;
    logic [4:0]         r_cnt;
    logic [4:0]         w_cnt_nxt;
    logic [31:0]        r_rem;
    logic [31:0]        w_rem_nxt;
    logic [31:0]        r_quo;
    logic [31:0]        w_quo_nxt;
    logic [31:0]        r_dvsr;
    logic [31:0]        w_dvsr_nxt;
    logic               r_neg_q;
    logic               w_neg_q_nxt;
    logic               r_neg_r;
    logic               w_neg_r_nxt;
    logic [DivResW-1:0] r_result;
    logic [DivResW-1:0] w_result_nxt;
    logic               r_ready;
    logic               w_ready_nxt;

    logic [32:0]        w_partial;
    logic [32:0]        w_diff;
    logic [31:0]        w_step_rem;
    logic [31:0]        w_step_quo;

    // Remainder stays below the divisor, so the 33-bit difference never
    // overflows and bit 32 is its sign.
    always_comb begin
        w_partial  = {r_rem, r_quo[31]};
        w_diff     = w_partial - {1'b0, r_dvsr};
        w_step_rem = w_diff[32] ? w_partial[31:0] : w_diff[31:0];
        w_step_quo = {r_quo[30:0], ~w_diff[32]};
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rem_nxt    = r_rem;
        w_quo_nxt    = r_quo;
        w_dvsr_nxt   = r_dvsr;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_result_nxt = r_result;
        w_ready_nxt  = r_ready;

        unique case (r_state)
            DivFree: begin
                w_ready_nxt  = DivResultNotReady;
                w_result_nxt = '0;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        w_state_nxt = DivByZero;
                    end else begin
                        w_state_nxt = DivOn;
                        w_cnt_nxt   = 5'd0;
                        w_rem_nxt   = 32'd0;
                        w_quo_nxt   = signed_div_i ? abs32(opdata1_i) : opdata1_i;
                        w_dvsr_nxt  = signed_div_i ? abs32(opdata2_i) : opdata2_i;
                        w_neg_q_nxt = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        w_neg_r_nxt = signed_div_i & opdata1_i[31];
                    end
                end
            end
            DivByZero: begin
                if (annul_i) begin
                    w_state_nxt = DivFree;
                end else begin
                    w_state_nxt = DivEnd;
                    w_rem_nxt   = 32'd0;
                    w_quo_nxt   = 32'd0;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    w_state_nxt = DivFree;
                end else begin
                    w_rem_nxt = w_step_rem;
                    w_quo_nxt = w_step_quo;
                    w_cnt_nxt = r_cnt + 5'd1;
                    // Last step also applies the sign correction.
                    if (r_cnt == 5'd31) begin
                        w_state_nxt = DivEnd;
                        w_cnt_nxt   = 5'd0;
                        w_quo_nxt   = r_neg_q ? (32'd0 - w_step_quo) : w_step_quo;
                        w_rem_nxt   = r_neg_r ? (32'd0 - w_step_rem) : w_step_rem;
                    end
                end
            end
            DivEnd: begin
                if (start_i == DivStart) begin
                    w_ready_nxt  = DivResultReady;
                    w_result_nxt = {r_rem, r_quo};
                end else begin
                    w_state_nxt  = DivFree;
                    w_ready_nxt  = DivResultNotReady;
                    w_result_nxt = '0;
                end
            end
            default: w_state_nxt = DivFree;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= DivFree;
            r_cnt    <= 5'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_dvsr   <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_ready  <= DivResultNotReady;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
            r_dvsr   <= w_dvsr_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: expected results queued at request time,
// popped and compared when ready_o rises.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb_q[$];

    ex_div u_dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // 64-bit signed arithmetic avoids the INT_MIN / -1 trap and truncates toward zero.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'h0;
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int          edges;
        bit          got;
        logic [63:0] exp_v;
        sb_q.push_back(exp);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        edges        = 0;
        got          = 1'b0;
        while (!got && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sgn;
            end
            if (ready_o) got = 1'b1;
        end
        chk({tag, "_ready"}, 64'(got), 64'd1);
        chk({tag, "_latency"}, 64'(edges), 64'(lat));
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            chk({tag, "_result"}, result_o, exp_v);
        end else begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold"}, {63'd0, ready_o} ^ result_o, 64'd1 ^ exp_v);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_drop"}, {63'd0, ready_o} | result_o, 64'd0);
    endtask

    task automatic watch_idle(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #12;
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_out", {63'd0, ready_o} | result_o, 64'd0);

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
        run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
        run_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
        run_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34);
        run_div("dbz", 1'b0, 32'd5, 32'd0, 64'h0, 3);
        run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);

        for (int k = 0; k < 8; k++) begin
            logic        sg;
            logic [31:0] a;
            logic [31:0] b;
            sg = k[0];
            a  = $urandom;
            b  = (k < 4) ? $urandom_range(1, 1000) : $urandom;
            if (b == 32'd0) b = 32'd3;
            run_div($sformatf("rnd%0d", k), sg, a, b, model(sg, a, b), 34);
        end

        // Annul at step 10, then a fresh request must still work.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd9;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        chk("annul_out", {63'd0, ready_o} | result_o, 64'd0);
        watch_idle("annul_noready", 40);
        run_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);

        // Asynchronous reset mid-DivOn.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd77;
        opdata2_i    = 32'd5;
        start_i      = 1'b1;
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_on_out", {63'd0, ready_o} | result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        watch_idle("rst_on_noready", 45);

        // Asynchronous reset while a result is presented clears it at once.
        @(negedge clk);
        opdata1_i = 32'd50;
        opdata2_i = 32'd4;
        start_i   = 1'b1;
        repeat (35) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_result", result_o, 64'h00000002_0000000C);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_end_ready", 64'(ready_o), 64'd0);
        chk("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        watch_idle("rst_end_noready", 40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-low (asserted when 0).
REQ-003 SHALL have port signed_div_i, input, 1, 1 = signed division (DIV), 0 = unsigned (DIVU); sampled at acceptance.
REQ-004 SHALL have port opdata1_i, input, 32, dividend; sampled at acceptance.
REQ-005 SHALL have port opdata2_i, input, 32, divisor; sampled at acceptance.
REQ-006 SHALL have port start_i, input, 1, request from EX stage; held high until ready_o seen.
REQ-007 SHALL have port annul_i, input, 1, cancel request (branch/flush); overrides start_i.
REQ-008 SHALL have port result_o, output, 64, {remainder[63:32], quotient[31:0]}; registered.
REQ-009 SHALL have port ready_o, output, 1, result valid; registered.

Function
REQ-010 SHALL implement four states: DivFree, DivByZero, DivOn, DivEnd.
REQ-011 DivFree: start_i=1 and annul_i=0 SHALL accept; divisor==0 -> DivByZero, else -> DivOn with iteration counter cleared; otherwise remain, ready_o=0, result_o=0.
REQ-012 Signed mode SHALL latch absolute values of operands (two's-complement negate when bit31=1); unsigned mode latches raw operands.
REQ-013 DivOn SHALL perform one restoring-division step per cycle: 33-bit trial subtraction of divisor from partial remainder; non-negative -> keep difference, shift in quotient bit 1; negative -> keep remainder, shift in 0.
REQ-014 DivOn SHALL run exactly 32 steps, then transition to DivEnd on the next edge.
REQ-015 On entering DivEnd (signed mode) quotient SHALL be negated iff operand signs differ; remainder SHALL take dividend's sign (negated iff dividend bit31=1).
REQ-016 DivByZero SHALL transition to DivEnd on the next edge with result_o=64'h0.
REQ-017 DivEnd SHALL drive ready_o=1 and hold result_o stable while start_i=1.
REQ-018 DivEnd with start_i=0 SHALL return to DivFree on the next edge, clearing ready_o and result_o.
REQ-019 Latency: acceptance edge = edge 1; normal result ready_o=1 after edge 34; divide-by-zero ready_o=1 after edge 3.
REQ-020 annul_i=1 in DivOn or DivByZero SHALL return to DivFree on the next edge with ready_o never asserted.
REQ-021 Operand changes after acceptance SHALL not affect the result.
REQ-022 Overflow case 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-023 ready_o SHALL be the sole stall-release indication; EX stage holds stallreq while start_i=1 and ready_o=0.

Reset
REQ-024 rst=0 SHALL immediately force state=DivFree, ready_o=0, result_o=64'h0, counter=0, datapath registers=0, regardless of clock.
REQ-025 Reset asserted mid-DivOn SHALL abandon the operation; after release, no ready_o until a new acceptance.

Structure
REQ-026 State encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/NotReady, DivStart/DivStop, and 64-bit result bus width SHALL live in the shared defines file.
REQ-027 Single module, no sub-modules; FSM and datapath in one block.

Verification
REQ-028 Unsigned 100/7, start held -> ready_o=1 after edge 34, result_o=64'h00000002_0000000E.
REQ-029 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=64'hFFFFFFFF_FFFFFFFD.
REQ-030 Signed 0x80000000/0xFFFFFFFF -> result_o=64'h00000000_80000000; unsigned 0xFFFFFFFF/1 -> 64'h00000000_FFFFFFFF.
REQ-031 Divide by zero (any dividend, e.g. 5/0) -> ready_o=1 after edge 3, result_o=0; drop start_i -> ready_o=0 next edge.
REQ-032 annul_i=1 at step 10 -> DivFree next edge, ready_o stays 0; a new 9/3 request then yields 64'h00000000_00000003 at its edge 34.
REQ-033 rst=0 pulsed asynchronously (between edges) during DivOn -> ready_o=0 and result_o=0 immediately; no later spurious ready_o.
